serial_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter. Sits directly upstream of the 6-bit shift-left preset register and drives that register's serial input and load inputs.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits a one-cycle start marker on ld, then shifts the word out MSB-first on sout, one bit per clk.
- Flags the final bit on done.

---
 rtl/serial_frame_tx.sv | 126 ++++++++++++
 tb/tb_serial_frame_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: one-cycle ld start marker, then the
// word MSB-first on sout, with done flagging the final payload bit.
module serial_frame_tx #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ld,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int unsigned LastCnt = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ld_q,    ld_d;
  logic             sout_q,  sout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             last_bit;
  logic             xfer;

  // Ready is a pure state/count decode so it never loops back through din_valid.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
  assign din_ready = (state_q == IDLE) || last_bit;
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = din;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(LastCnt);
        state_d = SHIFT;
      end
      SHIFT: begin
        // Exit is decided at cnt=0 before any decrement, so cnt never wraps.
        if (cnt_q == '0) begin
          if (xfer) begin
            shreg_d = din;
            state_d = START;
          end else begin
            shreg_d = shreg_q << 1;
            state_d = IDLE;
          end
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next-state values.
  always_comb begin
    ld_d   = 1'b0;
    sout_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      START: begin
        ld_d   = 1'b1;
        busy_d = 1'b1;
      end
      SHIFT: begin
        sout_d = shreg_d[WIDTH-1];
        busy_d = 1'b1;
        done_d = (cnt_d == '0);
      end
      default: begin
        ld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ld   = ld_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: WIDTH=6 instance for the main cases,
// WIDTH=8 instance for the wider-frame case.
module tb_serial_frame_tx;

  logic       clk;
  logic       clear;
  logic [5:0] din6;
  logic       valid6;
  logic       rdy6, ld6, sout6, busy6, done6;
  logic [7:0] din8;
  logic       valid8;
  logic       rdy8, ld8, sout8, busy8, done8;

  int n_tests;
  int n_fail;
  int cyc;
  int ld_cyc_a;
  int ld_cyc_b;

  serial_frame_tx #(.WIDTH(6), .CNT_W(3)) u_dut6 (
    .clk      (clk),
    .clear    (clear),
    .din      (din6),
    .din_valid(valid6),
    .din_ready(rdy6),
    .ld       (ld6),
    .sout     (sout6),
    .busy     (busy6),
    .done     (done6)
  );

  serial_frame_tx #(.WIDTH(8), .CNT_W(3)) u_dut8 (
    .clk      (clk),
    .clear    (clear),
    .din      (din8),
    .din_valid(valid8),
    .din_ready(rdy8),
    .ld       (ld8),
    .sout     (sout8),
    .busy     (busy8),
    .done     (done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output bundles are {ld, sout, busy, done, din_ready}.
  task automatic check_out(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {ld,sout,busy,done,rdy}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc6(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    check_out(tag, {ld6, sout6, busy6, done6, rdy6}, exp);
  endtask

  task automatic cyc8(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    check_out(tag, {ld8, sout8, busy8, done8, rdy8}, exp);
  endtask

  // First edge inside is the transfer edge; next inputs applied after START.
  task automatic expect_frame6(input string tag, input logic [5:0] word,
                               input logic [5:0] next_din, input logic next_valid,
                               output int ld_at);
    cyc6({tag, "_start"}, 5'b1_0_1_0_0);
    ld_at  = cyc;
    din6   = next_din;
    valid6 = next_valid;
    for (int k = 0; k < 6; k++) begin
      cyc6($sformatf("%s_bit%0d", tag, k),
           {1'b0, word[5-k], 1'b1, (k == 5), (k == 5)});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    clear   = 1'b0;
    din6    = '0;
    valid6  = 1'b0;
    din8    = '0;
    valid8  = 1'b0;

    // Reset state
    #3;
    check_out("reset6", {ld6, sout6, busy6, done6, rdy6}, 5'b0_0_0_0_1);
    check_out("reset8", {ld8, sout8, busy8, done8, rdy8}, 5'b0_0_0_0_1);
    #9 clear = 1'b1;

    // Single frame 101101 with a one-cycle valid pulse
    din6   = 6'b101101;
    valid6 = 1'b1;
    expect_frame6("single", 6'b101101, 6'b000000, 1'b0, ld_cyc_a);
    cyc6("single_idle", 5'b0_0_0_0_1);

    // Back-to-back frames with valid held high
    din6   = 6'b111000;
    valid6 = 1'b1;
    expect_frame6("b2b_a", 6'b111000, 6'b000111, 1'b1, ld_cyc_a);
    expect_frame6("b2b_b", 6'b000111, 6'b000000, 1'b0, ld_cyc_b);
    n_tests++;
    assert (ld_cyc_b - ld_cyc_a === 7) else begin
      n_fail++;
      $error("FAIL b2b_ld_spacing: observed %0d expected 7", ld_cyc_b - ld_cyc_a);
    end
    cyc6("b2b_idle", 5'b0_0_0_0_1);

    // Backpressure: second word changes while ready is low
    din6   = 6'b001011;
    valid6 = 1'b1;
    cyc6("bp_start", 5'b1_0_1_0_0);
    valid6 = 1'b0;
    din6   = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      logic [5:0] w;
      w = 6'b001011;
      cyc6($sformatf("bp_bit%0d", k), {1'b0, w[5-k], 1'b1, (k == 5), (k == 5)});
      if (k == 1) begin
        din6   = 6'b010101;
        valid6 = 1'b1;
      end
      if (k == 2) din6 = 6'b110011;
    end
    expect_frame6("bp_second", 6'b110011, 6'b000000, 1'b0, ld_cyc_a);
    cyc6("bp_idle", 5'b0_0_0_0_1);

    // Mid-frame reset after the third bit
    din6   = 6'b111111;
    valid6 = 1'b1;
    cyc6("rst_start", 5'b1_0_1_0_0);
    valid6 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc6($sformatf("rst_bit%0d", k), 5'b0_1_1_0_0);
    end
    #2 clear = 1'b0;
    #1;
    check_out("rst_abort", {ld6, sout6, busy6, done6, rdy6}, 5'b0_0_0_0_1);
    cyc6("rst_held", 5'b0_0_0_0_1);
    #3 clear = 1'b1;
    cyc6("rst_released", 5'b0_0_0_0_1);
    din6   = 6'b100001;
    valid6 = 1'b1;
    expect_frame6("rst_new", 6'b100001, 6'b000000, 1'b0, ld_cyc_a);
    cyc6("rst_new_idle", 5'b0_0_0_0_1);

    // Idle stability with din toggling
    for (int k = 0; k < 20; k++) begin
      din6 = 6'($urandom);
      cyc6($sformatf("idle%0d", k), 5'b0_0_0_0_1);
    end

    // WIDTH=8 frame A5: 9 cycles
    din8   = 8'hA5;
    valid8 = 1'b1;
    cyc8("w8_start", 5'b1_0_1_0_0);
    valid8 = 1'b0;
    din8   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] w;
      w = 8'hA5;
      cyc8($sformatf("w8_bit%0d", k), {1'b0, w[7-k], 1'b1, (k == 7), (k == 7)});
    end
    cyc8("w8_idle", 5'b0_0_0_0_1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
